// File: rtl/adc_frame_packer_pkg.sv
// Shared definitions for the ADC frame packer.
// Holds the channel/width constants, the per-channel FSM state type and the
// word-packing helpers used to build header and payload words.
package adc_frame_packer_pkg;

  // Channel and data-path widths (FT60x side)
  localparam int CNT_CHANNLS        = 4;
  localparam int CNT_CODE_NUM_CHNLS = 2;
  localparam int WIDTH_DATA         = 32;

  // ADC side
  localparam int WIDTH_SMP          = 16;
  localparam int WIDTH_SEQ          = 16;
  localparam logic [7:0] HDR_SYNC   = 8'hA5;

  // Default framing geometry
  localparam int FRAME_WORDS_DEF    = 8;
  localparam int FIFO_DEPTH_DEF     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } pk_state_t;

  // Header word: sync byte, channel id zero-padded to a byte, sequence number
  function automatic logic [WIDTH_DATA-1:0] hdr_word(
    input logic [CNT_CODE_NUM_CHNLS-1:0] chn,
    input logic [WIDTH_SEQ-1:0]          seq
  );
    return {HDR_SYNC, {(8-CNT_CODE_NUM_CHNLS){1'b0}}, chn, seq};
  endfunction

  // Payload word: the earlier sample occupies the low half
  function automatic logic [WIDTH_DATA-1:0] pair_word(
    input logic [WIDTH_SMP-1:0] first_smp,
    input logic [WIDTH_SMP-1:0] second_smp
  );
    return {second_smp, first_smp};
  endfunction

endpackage

// File: rtl/adc_frame_packer_fifo.sv
// Per-channel word FIFO with first-word fall-through.
// The head word is held in a register so rdata is valid one cycle after the
// write that makes the FIFO non-empty, and one cycle after each pop.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   push/wdata : write strobe and word (caller guarantees room)
//   pop        : pop request; ignored while empty
//   rdata      : head word (0 while empty)
//   nempt      : FIFO holds at least one word
//   count      : registered occupancy
module adc_frame_packer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     nempt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_inc_s;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             nempt_r;
  logic             pop_ok_s;

  assign pop_ok_s     = pop && nempt_r;
  assign rd_ptr_inc_s = rd_ptr_r + AW'(1);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next head word: the word behind the popped one, or a word pushed into an
  // (about to be) empty FIFO, which bypasses the storage array.
  always_comb begin
    head_nxt_s = head_r;
    if (pop_ok_s) begin
      if (count_r > (AW+1)'(1)) begin
        head_nxt_s = mem_r[rd_ptr_inc_s];
      end else if (push) begin
        head_nxt_s = wdata;
      end else begin
        head_nxt_s = '0;
      end
    end else if (!nempt_r && push) begin
      head_nxt_s = wdata;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Storage array write port (contents need no reset; pointers gate them)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered head/flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      nempt_r  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
      nempt_r <= (count_nxt_s != '0);
    end
  end

  assign rdata = head_r;
  assign nempt = nempt_r;
  assign count = count_r;

endmodule

// File: rtl/adc_frame_packer.sv
// ADC frame packer: splits the interleaved ADC sample stream into per-channel
// frames (one header word + FRAME_WORDS-1 payload words) and queues them in a
// per-channel FIFO feeding the FT60x pre-fetch stage. A frame is admitted only
// if the FIFO has room for all of it at frame start; otherwise it is dropped
// whole and counted.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   en                : packing enable, sampled at frame start only
//   stat_clr          : clears ovf and drop_cnt (wins over a same-cycle drop)
//   adc_vld/chn/smp   : one sample per cycle with its channel id
//   ch_req[c]         : pop request per channel
//   ch_dat[c]         : FWFT head word per channel
//   ch_nempt          : per-channel FIFO non-empty
//   ovf               : sticky per-channel frame-dropped flag
//   drop_cnt          : saturating count of dropped frames
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          stat_clr,
  input  logic                          adc_vld,
  input  logic [CNT_CODE_NUM_CHNLS-1:0] adc_chn,
  input  logic [WIDTH_SMP-1:0]          adc_smp,
  input  logic                          ch_req   [CNT_CHANNLS],
  output logic [WIDTH_DATA-1:0]         ch_dat   [CNT_CHANNLS],
  output logic [CNT_CHANNLS-1:0]        ch_nempt,
  output logic [CNT_CHANNLS-1:0]        ovf,
  output logic [15:0]                   drop_cnt
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int SCW = $clog2(2 * (FRAME_WORDS - 1));
  // Index of the last sample of a frame (first sample has index 0)
  localparam logic [SCW-1:0] LAST_SMP      = SCW'(2 * (FRAME_WORDS - 1) - 1);
  // Highest occupancy that still leaves room for a whole frame
  localparam logic [CW-1:0]  MAX_START_CNT = CW'(FIFO_DEPTH - FRAME_WORDS);

  logic [CNT_CHANNLS-1:0] drop_s;
  logic [CNT_CHANNLS-1:0] ovf_r;
  logic [15:0]            drop_cnt_r;

  for (genvar c = 0; c < CNT_CHANNLS; c++) begin : g_ch
    pk_state_t             state_r;
    pk_state_t             state_nxt_s;
    logic [SCW-1:0]        smp_cnt_r;
    logic [WIDTH_SEQ-1:0]  seq_r;
    logic [WIDTH_SMP-1:0]  pair_r;
    logic                  hit_s;
    logic                  room_s;
    logic                  last_s;
    logic                  push_s;
    logic                  drop_ev_s;
    logic [WIDTH_DATA-1:0] wdata_s;
    logic [CW-1:0]         fifo_cnt_s;

    assign hit_s  = adc_vld && (adc_chn == CNT_CODE_NUM_CHNLS'(c));
    assign room_s = (fifo_cnt_s <= MAX_START_CNT);
    assign last_s = (smp_cnt_r == LAST_SMP);

    // Channel FSM state register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_nxt_s;
      end
    end

    // Channel FSM next-state logic
    always_comb begin
      state_nxt_s = state_r;
      case (state_r)
        IDLE: begin
          if (hit_s && en) begin
            state_nxt_s = room_s ? FILL : DROP;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FILL, DROP: begin
          if (hit_s && last_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end

    // Channel FSM outputs: FIFO write and drop event
    always_comb begin
      push_s    = 1'b0;
      drop_ev_s = 1'b0;
      wdata_s   = '0;
      case (state_r)
        IDLE: begin
          if (hit_s && en && room_s) begin
            push_s  = 1'b1;
            wdata_s = hdr_word(CNT_CODE_NUM_CHNLS'(c), seq_r);
          end else if (hit_s && en) begin
            drop_ev_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
        end
        FILL: begin
          // Odd sample index completes a pair
          if (hit_s && smp_cnt_r[0]) begin
            push_s  = 1'b1;
            wdata_s = pair_word(pair_r, adc_smp);
          end else begin
            push_s = 1'b0;
          end
        end
        DROP:    push_s = 1'b0;
        default: push_s = 1'b0;
      endcase
    end

    // Sample counter, sequence number and pair register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        smp_cnt_r <= '0;
        seq_r     <= '0;
        pair_r    <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (hit_s && en) begin
              // Dropped frames consume a sequence number too
              seq_r     <= seq_r + WIDTH_SEQ'(1);
              smp_cnt_r <= SCW'(1);
              pair_r    <= adc_smp;
            end
          end
          FILL, DROP: begin
            if (hit_s) begin
              smp_cnt_r <= last_s ? '0 : smp_cnt_r + SCW'(1);
              if (!smp_cnt_r[0]) begin
                pair_r <= adc_smp;
              end
            end
          end
          default: smp_cnt_r <= '0;
        endcase
      end
    end

    assign drop_s[c] = drop_ev_s;

    adc_frame_packer_fifo #(
      .WIDTH (WIDTH_DATA),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (wdata_s),
      .pop   (ch_req[c]),
      .rdata (ch_dat[c]),
      .nempt (ch_nempt[c]),
      .count (fifo_cnt_s)
    );
  end

  // Drop statistics; at most one sample (hence one drop) per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r      <= '0;
      drop_cnt_r <= 16'd0;
    end else if (stat_clr) begin
      ovf_r      <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      ovf_r <= ovf_r | drop_s;
      if ((|drop_s) && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign ovf      = ovf_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_adc_frame_packer;
  import adc_frame_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        stat_clr;
  logic        adc_vld;
  logic [1:0]  adc_chn;
  logic [15:0] adc_smp;
  logic        ch_req   [4];
  logic [31:0] ch_dat   [4];
  logic [3:0]  ch_nempt;
  logic [3:0]  ovf;
  logic [15:0] drop_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  adc_frame_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .stat_clr (stat_clr),
    .adc_vld  (adc_vld),
    .adc_chn  (adc_chn),
    .adc_smp  (adc_smp),
    .ch_req   (ch_req),
    .ch_dat   (ch_dat),
    .ch_nempt (ch_nempt),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_hdr(input int c, input int s);
    return {8'hA5, 8'(c), 16'(s)};
  endfunction

  // Frame samples are base+0 .. base+13; payload word j (1..7) pairs two of them
  function automatic logic [31:0] exp_pay(input int base, input int j);
    return {16'(base + 2*j - 1), 16'(base + 2*j - 2)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; stat_clr = 1'b0; adc_vld = 1'b0;
    adc_chn = 2'd0; adc_smp = 16'd0;
    for (int i = 0; i < 4; i++) ch_req[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input int c, input logic [15:0] v);
    adc_vld = 1'b1; adc_chn = 2'(c); adc_smp = v;
    @(negedge clk);
    adc_vld = 1'b0;
  endtask

  task automatic send_frame(input int c, input int base);
    for (int i = 0; i < 14; i++) send(c, 16'(base + i));
  endtask

  task automatic pop_chk(input string tag, input int c, input logic [31:0] exp);
    chk({tag, "_nempt"}, 32'(ch_nempt[c]), 32'd1);
    chk(tag, ch_dat[c], exp);
    ch_req[c] = 1'b1;
    @(negedge clk);
    ch_req[c] = 1'b0;
  endtask

  task automatic pop_frame(input string tag, input int c, input int s, input int base);
    pop_chk({tag, "_hdr"}, c, exp_hdr(c, s));
    for (int j = 1; j < 8; j++) pop_chk($sformatf("%s_w%0d", tag, j), c, exp_pay(base, j));
  endtask

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  initial begin
    do_reset();
    @(negedge clk);
    // Reset state
    chk("rst_nempt", 32'(ch_nempt), 32'd0);
    for (int c = 0; c < 4; c++) chk($sformatf("rst_dat%0d", c), ch_dat[c], 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // 1: single frame on channel 1, samples 1..14
    send(1, 16'h0001);
    chk("t1_lat_nempt", 32'(ch_nempt), 32'h2);
    chk("t1_lat_dat", ch_dat[1], 32'hA5010000);
    for (int i = 2; i <= 14; i++) send(1, 16'(i));
    chk("t1_w1_lit", ch_dat[1], 32'hA5010000);
    pop_frame("t1", 1, 0, 1);
    chk("t1_empty", 32'(ch_nempt[1]), 32'd0);
    chk("t1_dat0", ch_dat[1], 32'd0);

    // 2: round robin, two frames per channel
    do_reset();
    for (int k = 0; k < 28; k++)
      for (int c = 0; c < 4; c++) send(c, 16'(c*256 + k));
    for (int c = 0; c < 4; c++)
      for (int f = 0; f < 2; f++) pop_frame($sformatf("t2_c%0d_f%0d", c, f), c, f, c*256 + f*14);
    chk("t2_empty", 32'(ch_nempt), 32'd0);

    // 3: no pops on ch0; frame 8 is dropped
    do_reset();
    for (int f = 0; f < 9; f++) begin
      if (f == 8) chk("t3_ovf_before", 32'(ovf), 32'd0);
      send_frame(0, f*14);
    end
    chk("t3_ovf", 32'(ovf), 32'h1);
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    for (int f = 0; f < 8; f++) pop_frame($sformatf("t3_f%0d", f), 0, f, f*14);
    chk("t3_drained", 32'(ch_nempt[0]), 32'd0);
    send_frame(0, 200);
    pop_frame("t3_seq9", 0, 9, 200);
    chk("t3_ovf_sticky", 32'(ovf), 32'h1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("t3_clr_ovf", 32'(ovf), 32'd0);
    chk("t3_clr_drop", 32'(drop_cnt), 32'd0);

    // 4: continuous pop on ch2 while pushing
    do_reset();
    ch_req[2] = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(exp_hdr(2, f));
      for (int j = 1; j < 8; j++) exp_q.push_back(exp_pay(256 + f*14, j));
      for (int i = 0; i < 14; i++) begin
        if (ch_nempt[2]) got_q.push_back(ch_dat[2]);
        send(2, 16'(256 + f*14 + i));
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (ch_nempt[2]) got_q.push_back(ch_dat[2]);
      @(negedge clk);
    end
    chk("t4_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got_q.size()) chk($sformatf("t4_w%0d", i), got_q[i], exp_q[i]);
    chk("t4_ovf", 32'(ovf), 32'd0);
    chk("t4_empty_req", 32'(ch_nempt[2]), 32'd0);
    ch_req[2] = 1'b0;
    send_frame(2, 300);
    pop_frame("t4_after", 2, 2, 300);
    chk("t4_after_empty", 32'(ch_nempt[2]), 32'd0);

    // 5: en falls mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) send(3, 16'(i));
    en = 1'b0;
    for (int i = 3; i < 14; i++) send(3, 16'(i));
    send(3, 16'h0999);
    pop_frame("t5", 3, 0, 0);
    chk("t5_discard", 32'(ch_nempt[3]), 32'd0);
    en = 1'b1;
    send_frame(3, 50);
    pop_frame("t5_next", 3, 1, 50);

    // 6: reset mid-frame, then stat_clr against a same-cycle drop
    do_reset();
    send_frame(0, 0);
    for (int i = 0; i < 5; i++) send(0, 16'(100 + i));
    chk("t6_pre_nempt", 32'(ch_nempt[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_nempt", 32'(ch_nempt), 32'd0);
    chk("t6_dat", ch_dat[0], 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    send_frame(0, 20);
    pop_frame("t6_seq0", 0, 0, 20);
    for (int f = 0; f < 8; f++) send_frame(1, f*14);
    stat_clr = 1'b1;
    send(1, 16'h0777);
    stat_clr = 1'b0;
    for (int i = 1; i < 14; i++) send(1, 16'(i));
    chk("t6_clr_ovf", 32'(ovf), 32'd0);
    chk("t6_clr_drop", 32'(drop_cnt), 32'd0);
    chk("t6_full_nempt", 32'(ch_nempt[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
